alu_rs_sched: RTL and testbench

//  Reservation station and issue scheduler for the ALU in the Tomasulo core.

---
 rtl/alu_rs_sched_if.sv | 46 ++++
 rtl/alu_rs_sched.sv | 211 +++++++++++++++++++++
 tb/tb_alu_rs_sched.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_rs_sched_if.sv
// alu_rs_sched_if: dispatch, CDB and ALU-issue buses of the ALU reservation station.
// Latency: none (wiring only).
// Backpressure: full_o throttles dispatch; alu_ready_i throttles issue.
interface alu_rs_sched_if #(
  parameter int ROB_BIT    = 4,
  parameter int DATA_WIDTH = 32
);
  // dispatch side
  logic                  disp_en_i;
  logic [2:0]            disp_tp;
  logic [5:0]            disp_op;
  logic                  disp_qj_v;
  logic [ROB_BIT-1:0]    disp_qj;
  logic [DATA_WIDTH-1:0] disp_vj;
  logic                  disp_qk_v;
  logic [ROB_BIT-1:0]    disp_qk;
  logic [DATA_WIDTH-1:0] disp_vk;
  logic [ROB_BIT-1:0]    disp_dest;
  logic                  full_o;
  // common data bus
  logic                  cdb_en_i;
  logic [ROB_BIT-1:0]    cdb_tag_i;
  logic [DATA_WIDTH-1:0] cdb_data_i;
  // ALU issue side
  logic                  alu_ready_i;
  logic                  alu_en_o;
  logic [2:0]            alu_tp_o;
  logic [5:0]            alu_op_o;
  logic [DATA_WIDTH-1:0] alu_lhs_o;
  logic [DATA_WIDTH-1:0] alu_rhs_o;
  logic [ROB_BIT-1:0]    alu_dest_o;

  modport master (
    output disp_en_i, disp_tp, disp_op, disp_qj_v, disp_qj, disp_vj,
           disp_qk_v, disp_qk, disp_vk, disp_dest,
           cdb_en_i, cdb_tag_i, cdb_data_i, alu_ready_i,
    input  full_o, alu_en_o, alu_tp_o, alu_op_o, alu_lhs_o, alu_rhs_o, alu_dest_o
  );

  modport slave (
    input  disp_en_i, disp_tp, disp_op, disp_qj_v, disp_qj, disp_vj,
           disp_qk_v, disp_qk, disp_vk, disp_dest,
           cdb_en_i, cdb_tag_i, cdb_data_i, alu_ready_i,
    output full_o, alu_en_o, alu_tp_o, alu_op_o, alu_lhs_o, alu_rhs_o, alu_dest_o
  );
endinterface

// File: rtl/alu_rs_sched.sv
// alu_rs_sched: ALU reservation station; captures CDB operands, issues one ready op per cycle.
// Latency: an entry ready at edge E (dispatch or CDB wakeup) issues at E+1 at the earliest.
// Backpressure: full_o holds the dispatcher; alu_ready_i=0 holds entries in place.
// Option: define ALU_RS_AGE_SEL_EN for oldest-first select (default: lowest ready index).
module alu_rs_sched #(
  parameter int RS_SIZE    = 8,
  parameter int RS_BIT     = 3,
  parameter int ROB_BIT    = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clear,
  alu_rs_sched_if.slave bus
);

  typedef struct packed {
    logic                  busy;
    logic [2:0]            tp;
    logic [5:0]            op;
    logic                  qj_v;
    logic [ROB_BIT-1:0]    qj;
    logic [DATA_WIDTH-1:0] vj;
    logic                  qk_v;
    logic [ROB_BIT-1:0]    qk;
    logic [DATA_WIDTH-1:0] vk;
    logic [ROB_BIT-1:0]    dest;
  } ent_t;

  ent_t                  ent_q [RS_SIZE];
  ent_t                  ent_d [RS_SIZE];
  logic [RS_BIT:0]       count_q, count_d;
  logic                  alu_en_q, alu_en_d;
  logic [2:0]            alu_tp_q, alu_tp_d;
  logic [5:0]            alu_op_q, alu_op_d;
  logic [DATA_WIDTH-1:0] alu_lhs_q, alu_lhs_d;
  logic [DATA_WIDTH-1:0] alu_rhs_q, alu_rhs_d;
  logic [ROB_BIT-1:0]    alu_dest_q, alu_dest_d;
`ifdef ALU_RS_AGE_SEL_EN
  logic [RS_BIT-1:0]     age_q [RS_SIZE];
  logic [RS_BIT-1:0]     age_d [RS_SIZE];
  logic [RS_BIT-1:0]     best_age;
`endif

  logic [RS_SIZE-1:0]    elig;
  logic                  sel_vld;
  logic [RS_BIT-1:0]     sel_idx;
  logic                  free_vld;
  logic [RS_BIT-1:0]     free_idx;
  logic                  full;
  logic                  do_issue;
  logic                  do_disp;
  ent_t                  new_ent;

  // full is decoded from the registered count so it never depends on this cycle's issue
  assign full     = (count_q == (RS_BIT+1)'(RS_SIZE));
  assign do_issue = en & ~clear & bus.alu_ready_i & sel_vld;
  assign do_disp  = en & ~clear & bus.disp_en_i & ~full & free_vld;

  assign bus.full_o     = full;
  assign bus.alu_en_o   = alu_en_q;
  assign bus.alu_tp_o   = alu_tp_q;
  assign bus.alu_op_o   = alu_op_q;
  assign bus.alu_lhs_o  = alu_lhs_q;
  assign bus.alu_rhs_o  = alu_rhs_q;
  assign bus.alu_dest_o = alu_dest_q;

  // pick the entry to issue from registered state only (oldest or lowest index)
  always_comb begin
    elig    = '0;
    sel_vld = 1'b0;
    sel_idx = '0;
`ifdef ALU_RS_AGE_SEL_EN
    best_age = '1;
`endif
    for (int i = 0; i < RS_SIZE; i++) begin
      elig[i] = ent_q[i].busy & ~ent_q[i].qj_v & ~ent_q[i].qk_v;
`ifdef ALU_RS_AGE_SEL_EN
      if (elig[i] && (!sel_vld || age_q[i] < best_age)) begin
        sel_vld  = 1'b1;
        sel_idx  = RS_BIT'(i);
        best_age = age_q[i];
      end
`else
      if (elig[i] && !sel_vld) begin
        sel_vld = 1'b1;
        sel_idx = RS_BIT'(i);
      end
`endif
    end
  end

  // lowest free slot; a slot freed by this cycle's issue is still busy here
  always_comb begin
    free_vld = 1'b0;
    free_idx = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!ent_q[i].busy && !free_vld) begin
        free_vld = 1'b1;
        free_idx = RS_BIT'(i);
      end
    end
  end

  // incoming entry, with a same-cycle CDB broadcast folded into its pending sources
  always_comb begin
    new_ent.busy = 1'b1;
    new_ent.tp   = bus.disp_tp;
    new_ent.op   = bus.disp_op;
    new_ent.qj_v = bus.disp_qj_v;
    new_ent.qj   = bus.disp_qj;
    new_ent.vj   = bus.disp_vj;
    new_ent.qk_v = bus.disp_qk_v;
    new_ent.qk   = bus.disp_qk;
    new_ent.vk   = bus.disp_vk;
    new_ent.dest = bus.disp_dest;
    if (bus.cdb_en_i && bus.disp_qj_v && bus.disp_qj == bus.cdb_tag_i) begin
      new_ent.qj_v = 1'b0;
      new_ent.vj   = bus.cdb_data_i;
    end
    if (bus.cdb_en_i && bus.disp_qk_v && bus.disp_qk == bus.cdb_tag_i) begin
      new_ent.qk_v = 1'b0;
      new_ent.vk   = bus.cdb_data_i;
    end
  end

  // next state: clear beats everything, en=0 freezes, otherwise wakeup/issue/dispatch
  always_comb begin
    ent_d      = ent_q;
    count_d    = count_q;
    alu_en_d   = 1'b0;
    alu_tp_d   = alu_tp_q;
    alu_op_d   = alu_op_q;
    alu_lhs_d  = alu_lhs_q;
    alu_rhs_d  = alu_rhs_q;
    alu_dest_d = alu_dest_q;
`ifdef ALU_RS_AGE_SEL_EN
    age_d      = age_q;
`endif
    if (clear) begin
      for (int i = 0; i < RS_SIZE; i++) ent_d[i].busy = 1'b0;
      count_d = '0;
    end else if (en) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (bus.cdb_en_i && ent_q[i].busy) begin
          if (ent_q[i].qj_v && ent_q[i].qj == bus.cdb_tag_i) begin
            ent_d[i].qj_v = 1'b0;
            ent_d[i].vj   = bus.cdb_data_i;
          end
          if (ent_q[i].qk_v && ent_q[i].qk == bus.cdb_tag_i) begin
            ent_d[i].qk_v = 1'b0;
            ent_d[i].vk   = bus.cdb_data_i;
          end
        end
      end
      if (do_issue) begin
        ent_d[sel_idx].busy = 1'b0;
        alu_en_d   = 1'b1;
        alu_tp_d   = ent_q[sel_idx].tp;
        alu_op_d   = ent_q[sel_idx].op;
        alu_lhs_d  = ent_q[sel_idx].vj;
        alu_rhs_d  = ent_q[sel_idx].vk;
        alu_dest_d = ent_q[sel_idx].dest;
      end
      if (do_disp) ent_d[free_idx] = new_ent;
`ifdef ALU_RS_AGE_SEL_EN
      // keep ages dense (0..count-1): close the gap left by the issued entry
      if (do_issue) begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (ent_q[i].busy && age_q[i] > age_q[sel_idx]) age_d[i] = age_q[i] - RS_BIT'(1);
        end
      end
      if (do_disp) age_d[free_idx] = count_q[RS_BIT-1:0] - RS_BIT'(do_issue);
`endif
      count_d = count_q + (RS_BIT+1)'(do_disp) - (RS_BIT+1)'(do_issue);
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_q[i] <= '0;
`ifdef ALU_RS_AGE_SEL_EN
        age_q[i] <= '0;
`endif
      end
      count_q    <= '0;
      alu_en_q   <= 1'b0;
      alu_tp_q   <= '0;
      alu_op_q   <= '0;
      alu_lhs_q  <= '0;
      alu_rhs_q  <= '0;
      alu_dest_q <= '0;
    end else begin
      ent_q      <= ent_d;
`ifdef ALU_RS_AGE_SEL_EN
      age_q      <= age_d;
`endif
      count_q    <= count_d;
      alu_en_q   <= alu_en_d;
      alu_tp_q   <= alu_tp_d;
      alu_op_q   <= alu_op_d;
      alu_lhs_q  <= alu_lhs_d;
      alu_rhs_q  <= alu_rhs_d;
      alu_dest_q <= alu_dest_d;
    end
  end

endmodule

// File: tb/tb_alu_rs_sched.sv
// tb_alu_rs_sched: directed bench for the ALU reservation station with an issue scoreboard.
module tb_alu_rs_sched;
  localparam int RS_SIZE = 8;
  localparam int RS_BIT  = 3;
  localparam int ROB_BIT = 4;
  localparam int DW      = 32;

  typedef struct packed {
    logic [2:0]         tp;
    logic [5:0]         op;
    logic [DW-1:0]      lhs;
    logic [DW-1:0]      rhs;
    logic [ROB_BIT-1:0] dest;
  } iss_t;

  logic clk = 1'b0;
  logic rst, en, clear;
  iss_t exp_q [$];
  int   n_cmp = 0;
  int   n_err = 0;

  alu_rs_sched_if #(.ROB_BIT(ROB_BIT), .DATA_WIDTH(DW)) bus ();

  alu_rs_sched #(.RS_SIZE(RS_SIZE), .RS_BIT(RS_BIT), .ROB_BIT(ROB_BIT), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clear (clear),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // advance one edge, then check any issued op against the scoreboard head
  task automatic tick();
    iss_t got, e;
    @(posedge clk);
    #1;
    if (bus.alu_en_o === 1'b1) begin
      got = '{tp: bus.alu_tp_o, op: bus.alu_op_o, lhs: bus.alu_lhs_o,
              rhs: bus.alu_rhs_o, dest: bus.alu_dest_o};
      if (exp_q.size() == 0) begin
        chk("spurious_issue", 80'(got), 80'h0);
      end else begin
        e = exp_q.pop_front();
        chk("issue_pkt", 80'(got), 80'(e));
      end
    end
  endtask

  task automatic push_exp(input logic [2:0] tp, input logic [5:0] op, input logic [DW-1:0] lhs,
                          input logic [DW-1:0] rhs, input logic [ROB_BIT-1:0] dest);
    iss_t e;
    e = '{tp: tp, op: op, lhs: lhs, rhs: rhs, dest: dest};
    exp_q.push_back(e);
  endtask

  task automatic set_disp(input logic [2:0] tp, input logic [5:0] op,
                          input logic qjv, input logic [ROB_BIT-1:0] qj, input logic [DW-1:0] vj,
                          input logic qkv, input logic [ROB_BIT-1:0] qk, input logic [DW-1:0] vk,
                          input logic [ROB_BIT-1:0] dest);
    bus.disp_en_i = 1'b1;
    bus.disp_tp   = tp;
    bus.disp_op   = op;
    bus.disp_qj_v = qjv;
    bus.disp_qj   = qj;
    bus.disp_vj   = vj;
    bus.disp_qk_v = qkv;
    bus.disp_qk   = qk;
    bus.disp_vk   = vk;
    bus.disp_dest = dest;
  endtask

  task automatic set_cdb(input logic v, input logic [ROB_BIT-1:0] tag, input logic [DW-1:0] d);
    bus.cdb_en_i   = v;
    bus.cdb_tag_i  = tag;
    bus.cdb_data_i = d;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; clear = 1'b0;
    set_disp(3'd0, 6'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd0);
    bus.disp_en_i   = 1'b0;
    bus.alu_ready_i = 1'b1;
    set_cdb(1'b0, 4'd0, 32'd0);

    // reset state
    tick(); tick();
    chk("rst_alu_en", 80'(bus.alu_en_o), 80'd0);
    chk("rst_full", 80'(bus.full_o), 80'd0);
    chk("rst_lhs", 80'(bus.alu_lhs_o), 80'd0);
    chk("rst_rhs", 80'(bus.alu_rhs_o), 80'd0);
    chk("rst_dest", 80'(bus.alu_dest_o), 80'd0);
    rst = 1'b0;

    // 1: ready dispatch issues one edge later
    set_disp(3'd1, 6'd0, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7, 4'd3);
    push_exp(3'd1, 6'd0, 32'd5, 32'd7, 4'd3);
    tick(); chk("t1_no_issue_at_disp", 80'(bus.alu_en_o), 80'd0);
    bus.disp_en_i = 1'b0;
    tick(); chk("t1_issue", 80'(bus.alu_en_o), 80'd1);
    tick(); chk("t1_idle", 80'(bus.alu_en_o), 80'd0);
    chk("t1_hold_lhs", 80'(bus.alu_lhs_o), 80'd5);
    chk("t1_full", 80'(bus.full_o), 80'd0);

    // 2: rs1 pending; wrong tag ignored, right tag wakes, issue one edge after the CDB
    set_disp(3'd2, 6'd3, 1'b1, 4'd2, 32'hBAD, 1'b0, 4'd0, 32'h20, 4'd5);
    tick(); chk("t2_pending", 80'(bus.alu_en_o), 80'd0);
    bus.disp_en_i = 1'b0;
    set_cdb(1'b1, 4'd3, 32'hDEAD);
    tick(); chk("t2_wrong_tag", 80'(bus.alu_en_o), 80'd0);
    set_cdb(1'b1, 4'd2, 32'h10);
    push_exp(3'd2, 6'd3, 32'h10, 32'h20, 4'd5);
    tick(); chk("t2_wake_edge", 80'(bus.alu_en_o), 80'd0);
    set_cdb(1'b0, 4'd0, 32'd0);
    tick(); chk("t2_issue", 80'(bus.alu_en_o), 80'd1);
    tick(); chk("t2_idle", 80'(bus.alu_en_o), 80'd0);

    // 3: same-cycle CDB capture at dispatch
    set_disp(3'd4, 6'd9, 1'b0, 4'd0, 32'h11, 1'b1, 4'd6, 32'hBAD, 4'd7);
    set_cdb(1'b1, 4'd6, 32'd9);
    push_exp(3'd4, 6'd9, 32'h11, 32'd9, 4'd7);
    tick(); chk("t3_disp", 80'(bus.alu_en_o), 80'd0);
    bus.disp_en_i = 1'b0;
    set_cdb(1'b0, 4'd0, 32'd0);
    tick(); chk("t3_issue", 80'(bus.alu_en_o), 80'd1);
    tick(); chk("t3_idle", 80'(bus.alu_en_o), 80'd0);

    // 4: fill, overflow drop, drain on consecutive cycles
    bus.alu_ready_i = 1'b0;
    for (int k = 0; k < RS_SIZE; k++) begin
      set_disp(3'(k), 6'(k + 16), 1'b0, 4'd0, 32'(100 + k), 1'b0, 4'd0, 32'(3 * k), 4'(k));
      push_exp(3'(k), 6'(k + 16), 32'(100 + k), 32'(3 * k), 4'(k));
      tick(); chk("t4_full_fill", 80'(bus.full_o), 80'(k == RS_SIZE - 1));
    end
    set_disp(3'd7, 6'd63, 1'b0, 4'd0, 32'hFFFF, 1'b0, 4'd0, 32'hFFFF, 4'd15);
    tick(); chk("t4_full_hold", 80'(bus.full_o), 80'd1);
    chk("t4_no_issue_busy", 80'(bus.alu_en_o), 80'd0);
    bus.disp_en_i   = 1'b0;
    bus.alu_ready_i = 1'b1;
    tick(); chk("t4_first_issue", 80'(bus.alu_en_o), 80'd1);
    chk("t4_full_drop", 80'(bus.full_o), 80'd0);
    for (int k = 1; k < RS_SIZE; k++) begin
      tick(); chk("t4_drain", 80'(bus.alu_en_o), 80'd1);
    end
    tick(); chk("t4_empty", 80'(bus.alu_en_o), 80'd0);

    // 5: clear flushes waiting entries and a same-cycle dispatch
    bus.alu_ready_i = 1'b0;
    set_disp(3'd1, 6'd1, 1'b1, 4'd9, 32'd0, 1'b0, 4'd0, 32'd1, 4'd1);
    tick();
    set_disp(3'd1, 6'd2, 1'b0, 4'd0, 32'd2, 1'b1, 4'd10, 32'd0, 4'd2);
    tick();
    set_disp(3'd1, 6'd3, 1'b0, 4'd0, 32'd3, 1'b0, 4'd0, 32'd4, 4'd4);
    tick();
    set_disp(3'd1, 6'd4, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd6, 4'd8);
    clear = 1'b1;
    bus.alu_ready_i = 1'b1;
    tick(); chk("t5_clear_no_issue", 80'(bus.alu_en_o), 80'd0);
    chk("t5_clear_full", 80'(bus.full_o), 80'd0);
    clear = 1'b0;
    bus.disp_en_i = 1'b0;
    set_cdb(1'b1, 4'd9, 32'h99);
    tick(); chk("t5_stale_cdb_a", 80'(bus.alu_en_o), 80'd0);
    set_cdb(1'b1, 4'd10, 32'hAA);
    tick(); chk("t5_stale_cdb_b", 80'(bus.alu_en_o), 80'd0);
    set_cdb(1'b0, 4'd0, 32'd0);
    tick(); chk("t5_stale_cdb_c", 80'(bus.alu_en_o), 80'd0);

    // en=0 ignores dispatch and freezes a ready entry
    en = 1'b0;
    set_disp(3'd5, 6'd5, 1'b0, 4'd0, 32'd50, 1'b0, 4'd0, 32'd51, 4'd9);
    tick(); chk("en0_drop_disp", 80'(bus.alu_en_o), 80'd0);
    bus.disp_en_i = 1'b0;
    en = 1'b1;
    tick(); chk("en0_nothing_stored", 80'(bus.alu_en_o), 80'd0);
    set_disp(3'd6, 6'd6, 1'b0, 4'd0, 32'd60, 1'b0, 4'd0, 32'd61, 4'd10);
    push_exp(3'd6, 6'd6, 32'd60, 32'd61, 4'd10);
    tick();
    bus.disp_en_i = 1'b0;
    en = 1'b0;
    tick(); chk("en0_freeze", 80'(bus.alu_en_o), 80'd0);
    en = 1'b1;
    tick(); chk("en0_resume_issue", 80'(bus.alu_en_o), 80'd1);
    tick(); chk("en0_idle", 80'(bus.alu_en_o), 80'd0);

    // 6a: pending idx0, ready idx1; idx1 goes first, woken idx0 next
    set_disp(3'd3, 6'd4, 1'b1, 4'd11, 32'd0, 1'b0, 4'd0, 32'd1, 4'd1);
    tick();
    set_disp(3'd3, 6'd5, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0, 32'd3, 4'd2);
    push_exp(3'd3, 6'd5, 32'd2, 32'd3, 4'd2);
    tick(); chk("t6_b_disp", 80'(bus.alu_en_o), 80'd0);
    bus.disp_en_i = 1'b0;
    set_cdb(1'b1, 4'd11, 32'h77);
    push_exp(3'd3, 6'd4, 32'h77, 32'd1, 4'd1);
    tick(); chk("t6_b_issue", 80'(bus.alu_en_o), 80'd1);
    set_cdb(1'b0, 4'd0, 32'd0);
    tick(); chk("t6_a_issue", 80'(bus.alu_en_o), 80'd1);
    tick(); chk("t6_ab_idle", 80'(bus.alu_en_o), 80'd0);

    // 6b: older entry at higher index vs newer entry at idx0
    bus.alu_ready_i = 1'b0;
    set_disp(3'd2, 6'd10, 1'b0, 4'd0, 32'd30, 1'b0, 4'd0, 32'd31, 4'd3);
    push_exp(3'd2, 6'd10, 32'd30, 32'd31, 4'd3);
    tick();
    set_disp(3'd2, 6'd11, 1'b0, 4'd0, 32'd40, 1'b0, 4'd0, 32'd41, 4'd4);
    tick();
    set_disp(3'd2, 6'd12, 1'b0, 4'd0, 32'd50, 1'b0, 4'd0, 32'd51, 4'd5);
    tick();
    bus.disp_en_i   = 1'b0;
    bus.alu_ready_i = 1'b1;
    tick(); chk("t6_c_issue", 80'(bus.alu_en_o), 80'd1);
    bus.alu_ready_i = 1'b0;
    set_disp(3'd2, 6'd13, 1'b0, 4'd0, 32'd60, 1'b0, 4'd0, 32'd61, 4'd6);
    tick(); chk("t6_f_disp", 80'(bus.alu_en_o), 80'd0);
    bus.disp_en_i = 1'b0;
`ifdef ALU_RS_AGE_SEL_EN
    push_exp(3'd2, 6'd11, 32'd40, 32'd41, 4'd4);
    push_exp(3'd2, 6'd12, 32'd50, 32'd51, 4'd5);
    push_exp(3'd2, 6'd13, 32'd60, 32'd61, 4'd6);
`else
    push_exp(3'd2, 6'd13, 32'd60, 32'd61, 4'd6);
    push_exp(3'd2, 6'd11, 32'd40, 32'd41, 4'd4);
    push_exp(3'd2, 6'd12, 32'd50, 32'd51, 4'd5);
`endif
    bus.alu_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(); chk("t6_order_issue", 80'(bus.alu_en_o), 80'd1);
    end
    tick(); chk("t6_final_idle", 80'(bus.alu_en_o), 80'd0);

    chk("sb_empty", 80'(exp_q.size()), 80'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
